// File: rtl/z80_bus_responder.sv
// z80_bus_responder
//   Memory/IO target for the tv80s external bus. It decodes the Z80 bus strobes, serves
//   memory and IO reads and writes from internal arrays, inserts programmable wait states,
//   and answers interrupt-acknowledge cycles with a fixed vector. All logic runs on the
//   rising clock edge.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   A, dout               CPU address bus and CPU write data
//   di                    read data returned to the CPU (registered)
//   mreq_n .. rfsh_n      Z80 bus strobes
//   wait_n                wait request to the CPU
//   ld_en/addr/data       preload write port (memory only; it always has priority below a
//                         CPU write to the same address)
//   rd_count, wr_count    completed read accesses / committed write accesses (they wrap)
//
// Optional feature
//   Z80_BUS_RESPONDER_ROM_PROTECT_EN: a CPU memory write below ROM_TOP completes the
//   handshake but neither changes memory nor counts as a committed write.

module z80_bus_responder #(
    parameter int unsigned AW             = 16,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned M1_WAIT_STATES = 0,
    parameter logic [7:0]  INT_VECTOR     = 8'hFF,
    parameter logic [15:0] ROM_TOP        = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int unsigned Depth   = 2 ** AW;
    localparam int unsigned WaitSum = WAIT_STATES + M1_WAIT_STATES;
    // The wait counter is 4 bits wide, so both wait totals saturate at 15.
    localparam logic [3:0] WaitBase = (WAIT_STATES > 15) ? 4'd15 : 4'(WAIT_STATES);
    localparam logic [3:0] WaitM1   = (WaitSum > 15) ? 4'd15 : 4'(WaitSum);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StHold} state_e;
    typedef enum logic [2:0] {
        KindNone, KindMemRd, KindMemWr, KindIoRd, KindIoWr, KindInta
    } kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic [7:0]  mem_q [Depth];
    logic [7:0]  io_q  [256];

    logic        mem_we, io_we;
    logic        rom_blk;
    kind_e       req_kind;
    logic [3:0]  req_wait;
    logic        still_req;
    logic        memrd, memwr, iord, iowr, inta;
    logic [AW-1:0] mem_addr;

    assign mem_addr = A[AW-1:0];

    // Bus decode. A refresh cycle (mreq_n low, rfsh_n low, no strobe) decodes to nothing.
    assign memrd = !mreq_n && !rd_n && rfsh_n;
    assign memwr = !mreq_n && !wr_n;
    assign iord  = !iorq_n && m1_n && !rd_n;
    assign iowr  = !iorq_n && m1_n && !wr_n;
    assign inta  = !iorq_n && !m1_n;

    always_comb begin
        req_kind = KindNone;
        if (inta)       req_kind = KindInta;
        else if (iord)  req_kind = KindIoRd;
        else if (iowr)  req_kind = KindIoWr;
        else if (memrd) req_kind = KindMemRd;
        else if (memwr) req_kind = KindMemWr;
    end

    // Opcode fetches get the extra M1 wait states on top of the base count.
    assign req_wait = (req_kind == KindMemRd && !m1_n) ? WaitM1 : WaitBase;

    // True while the strobes of the latched request are still asserted.
    always_comb begin
        still_req = 1'b0;
        unique case (kind_q)
            KindMemRd: still_req = memrd;
            KindMemWr: still_req = memwr;
            KindIoRd:  still_req = iord;
            KindIoWr:  still_req = iowr;
            KindInta:  still_req = inta;
            default:   still_req = 1'b0;
        endcase
    end

`ifdef Z80_BUS_RESPONDER_ROM_PROTECT_EN
    assign rom_blk = (A < ROM_TOP);
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign rom_blk        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        di_d       = di_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        io_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_kind != KindNone) begin
                    kind_d = req_kind;
                    if (req_wait == 4'd0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = req_wait;
                    end
                end
            end
            StWait: begin
                if (!still_req) begin
                    state_d = StIdle;  // CPU gave up the cycle: no access, no count
                end else if (cnt_q == 4'd1) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                state_d = StHold;
                unique case (kind_q)
                    KindMemRd: begin
                        di_d       = mem_q[mem_addr];
                        rd_count_d = rd_count_q + 16'd1;
                    end
                    KindIoRd: begin
                        di_d       = io_q[A[7:0]];
                        rd_count_d = rd_count_q + 16'd1;
                    end
                    KindInta: begin
                        di_d       = INT_VECTOR;
                        rd_count_d = rd_count_q + 16'd1;
                    end
                    KindMemWr: begin
                        if (!rom_blk) begin
                            mem_we     = 1'b1;
                            wr_count_d = wr_count_q + 16'd1;
                        end
                    end
                    KindIoWr: begin
                        io_we      = 1'b1;
                        wr_count_d = wr_count_q + 16'd1;
                    end
                    default: ;
                endcase
            end
            StHold: begin
                // Wait for the whole bus cycle to end so each cycle yields one access.
                if (rd_n && wr_n && mreq_n && iorq_n) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            kind_q     <= KindNone;
            cnt_q      <= 4'd0;
            di_q       <= 8'h00;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            di_q       <= di_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage is not reset. The CPU write comes last so it wins over a same-address preload.
    // mem_we/io_we depend on state_q, so an asynchronous reset drops any pending write.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr[AW-1:0]] <= ld_data;
        end
        if (mem_we) begin
            mem_q[mem_addr] <= dout;
        end
        if (io_we) begin
            io_q[A[7:0]] <= dout;
        end
    end

    // wait_n drops as soon as the state enters StWait and releases at once on abort or reset.
    assign wait_n   = !(state_q == StWait && still_req);
    assign di       = di_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder
//   Directed bench for z80_bus_responder. It runs two instances on one shared bus: u_dut0
//   with no wait states and u_dut1 with WAIT_STATES=2 and M1_WAIT_STATES=1. Every bus cycle
//   holds its strobes long enough for both instances to finish, so both see the same
//   accesses.

module tb_z80_bus_responder;

    localparam int KMemRd   = 0;
    localparam int KFetch   = 1;
    localparam int KMemWr   = 2;
    localparam int KIoRd    = 3;
    localparam int KIoWr    = 4;
    localparam int KInta    = 5;
    localparam int KRefresh = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  di0, di1;
    logic        wait0, wait1;
    logic [15:0] rd0, rd1, wr0, wr1;

    int checks   = 0;
    int failures = 0;
    int wl0, wl1;
    logic [7:0] di0_n1, di0_n2;
    logic [15:0] exp_rd, exp_wr;

    always #5 clk = ~clk;

    z80_bus_responder #(
        .AW(16), .WAIT_STATES(0), .M1_WAIT_STATES(0), .INT_VECTOR(8'hFF), .ROM_TOP(16'h4000)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .di(di0),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .rfsh_n(rfsh_n), .wait_n(wait0), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rd_count(rd0), .wr_count(wr0)
    );

    z80_bus_responder #(
        .AW(16), .WAIT_STATES(2), .M1_WAIT_STATES(1), .INT_VECTOR(8'hFF), .ROM_TOP(16'h4000)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .di(di1),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .rfsh_n(rfsh_n), .wait_n(wait1), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rd_count(rd1), .wr_count(wr1)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One CPU bus cycle: strobes held for six cycles, wait_n-low cycles counted per instance.
    task automatic bus(input int kind, input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        A = addr; dout = data;
        case (kind)
            KMemRd:   begin mreq_n = 1'b0; rd_n = 1'b0; end
            KFetch:   begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            KMemWr:   begin mreq_n = 1'b0; wr_n = 1'b0; end
            KIoRd:    begin iorq_n = 1'b0; rd_n = 1'b0; end
            KIoWr:    begin iorq_n = 1'b0; wr_n = 1'b0; end
            KInta:    begin iorq_n = 1'b0; m1_n = 1'b0; end
            default:  begin mreq_n = 1'b0; rfsh_n = 1'b0; end
        endcase
        wl0 = 0; wl1 = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!wait0) wl0++;
            if (!wait1) wl1++;
            if (i == 1) di0_n1 = di0;
            if (i == 2) di0_n2 = di0;
        end
        bus_idle();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; A = 16'h0000; dout = 8'h00;
        ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        bus_idle();
        exp_rd = 16'd0; exp_wr = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_di", {8'h00, di0}, 16'h0000);
        check_eq("reset_wait", {14'd0, wait0, wait1}, 16'h0003);
        check_eq("reset_rd", rd1, 16'd0);
        check_eq("reset_wr", wr0, 16'd0);
        reset_n = 1'b1;

        preload(16'h7582, 8'h91);
        preload(16'h0000, 8'hDD);
        preload(16'h0012, 8'hA5);
        preload(16'h1000, 8'h3C);
        preload(16'h0100, 8'h11);
        preload(16'h4000, 8'h22);

        // Plain read with and without wait states.
        bus(KMemRd, 16'h7582, 8'h00); exp_rd++;
        check_eq("rd_early_di0", {8'h00, di0_n1}, 16'h0000);
        check_eq("rd_latency_di0", {8'h00, di0_n2}, 16'h0091);
        check_eq("rd_di1", {8'h00, di1}, 16'h0091);
        check_eq("rd_wlow0", 16'(wl0), 16'd0);
        check_eq("rd_wlow1", 16'(wl1), 16'd2);
        check_eq("rd_count0", rd0, exp_rd);

        // Write half of a read-modify-write, then read it back.
        bus(KMemWr, 16'h7582, 8'hC8); exp_wr++;
        check_eq("wr_wlow1", 16'(wl1), 16'd2);
        check_eq("rmw_rd0", rd0, exp_rd);
        check_eq("rmw_wr0", wr0, exp_wr);
        check_eq("rmw_wr1", wr1, exp_wr);
        bus(KMemRd, 16'h7582, 8'h00); exp_rd++;
        check_eq("rmw_data0", {8'h00, di0}, 16'h00C8);
        check_eq("rmw_data1", {8'h00, di1}, 16'h00C8);

        // Opcode fetch gets the extra M1 wait state.
        bus(KFetch, 16'h0000, 8'h00); exp_rd++;
        check_eq("m1_wlow1", 16'(wl1), 16'd3);
        check_eq("m1_wlow0", 16'(wl0), 16'd0);
        check_eq("m1_di1", {8'h00, di1}, 16'h00DD);
        check_eq("m1_di0", {8'h00, di0}, 16'h00DD);

        // Refresh is ignored.
        bus(KRefresh, 16'h7582, 8'h00);
        check_eq("rfsh_di0", {8'h00, di0}, 16'h00DD);
        check_eq("rfsh_di1", {8'h00, di1}, 16'h00DD);
        check_eq("rfsh_wlow1", 16'(wl1), 16'd0);
        check_eq("rfsh_rd1", rd1, exp_rd);
        check_eq("rfsh_wr1", wr1, exp_wr);

        // IO space is separate from memory.
        bus(KIoWr, 16'h0012, 8'h55); exp_wr++;
        bus(KIoRd, 16'h0012, 8'h00); exp_rd++;
        check_eq("io_rd0", {8'h00, di0}, 16'h0055);
        check_eq("io_rd1", {8'h00, di1}, 16'h0055);
        bus(KMemRd, 16'h0012, 8'h00); exp_rd++;
        check_eq("io_mem_intact0", {8'h00, di0}, 16'h00A5);
        check_eq("io_mem_intact1", {8'h00, di1}, 16'h00A5);

        // Interrupt acknowledge.
        bus(KInta, 16'h0000, 8'h00); exp_rd++;
        check_eq("inta_di0", {8'h00, di0}, 16'h00FF);
        check_eq("inta_di1", {8'h00, di1}, 16'h00FF);
        check_eq("inta_wlow1", 16'(wl1), 16'd2);
        check_eq("cnt_rd0", rd0, exp_rd);
        check_eq("cnt_rd1", rd1, exp_rd);
        check_eq("cnt_wr0", wr0, exp_wr);

        // Writes below and at ROM_TOP.
        bus(KMemWr, 16'h0100, 8'h77);
`ifndef Z80_BUS_RESPONDER_ROM_PROTECT_EN
        exp_wr++;
`endif
        check_eq("rom_low_wr0", wr0, exp_wr);
        check_eq("rom_low_wlow1", 16'(wl1), 16'd2);
        bus(KMemWr, 16'h4000, 8'h77); exp_wr++;
        check_eq("rom_top_wr1", wr1, exp_wr);
        bus(KMemRd, 16'h0100, 8'h00); exp_rd++;
`ifdef Z80_BUS_RESPONDER_ROM_PROTECT_EN
        check_eq("rom_low_data0", {8'h00, di0}, 16'h0011);
        check_eq("rom_low_data1", {8'h00, di1}, 16'h0011);
`else
        check_eq("rom_low_data0", {8'h00, di0}, 16'h0077);
        check_eq("rom_low_data1", {8'h00, di1}, 16'h0077);
`endif
        bus(KMemRd, 16'h4000, 8'h00); exp_rd++;
        check_eq("rom_top_data0", {8'h00, di0}, 16'h0077);
        check_eq("rom_top_data1", {8'h00, di1}, 16'h0077);

        // Reset in the middle of a waited write.
        @(negedge clk);
        A = 16'h1000; dout = 8'hAA; mreq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_wait1", {15'd0, wait1}, 16'd0);
        reset_n = 1'b0;
        #1;
        check_eq("rst_wait", {14'd0, wait0, wait1}, 16'h0003);
        check_eq("rst_rd1", rd1, 16'd0);
        check_eq("rst_wr0", wr0, 16'd0);
        check_eq("rst_wr1", wr1, 16'd0);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        reset_n = 1'b1;
        bus(KMemRd, 16'h1000, 8'h00);
        check_eq("rst_mem0", {8'h00, di0}, 16'h003C);
        check_eq("rst_mem1", {8'h00, di1}, 16'h003C);
        check_eq("rst_post_rd1", rd1, 16'd1);
        check_eq("rst_post_wr1", wr1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
